// File: rtl/traf_pkg.sv
// traf_pkg: light/phase codes, monitor states and phase helpers shared by the traffic monitor
package traf_pkg;
    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;
    typedef enum logic [1:0] {PH_HG, PH_HY, PH_SG, PH_SY} phase_t;
    typedef enum logic {UNSYNC, TRACK} mon_st_t;
    function automatic phase_t next_phase(input phase_t ph);
        return phase_t'(ph + 2'd1);
    endfunction
    function automatic int exp_dwell(input phase_t ph, input int green_cyc, input int yellow_cyc);
        return (ph == PH_HG || ph == PH_SG) ? green_cyc : yellow_cyc;
    endfunction
endpackage

// File: rtl/traf_decode.sv
// traf_decode: maps a {highway, side} light pair onto a phase code plus a legality bit
module traf_decode
    import traf_pkg::*;
(
    input  logic [1:0] highway,
    input  logic [1:0] side,
    output logic [1:0] ph,
    output logic       valid
);
    always_comb begin
        valid = ({highway, side} == {GRN, RED}) || ({highway, side} == {YEL, RED}) ||
                ({highway, side} == {RED, GRN}) || ({highway, side} == {RED, YEL});
        ph = highway == GRN ? PH_HG : highway == YEL ? PH_HY : side == GRN ? PH_SG : PH_SY;
    end
endmodule

// File: rtl/traf_mon.sv
// traf_mon: passive checker of phase order, dwell length and illegal codes on the traffic light bus
module traf_mon
    import traf_pkg::*;
#(
    parameter int GREEN_CYC  = 11,
    parameter int YELLOW_CYC = 4,
    parameter int CNT_W      = 8,
    parameter int CYC_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       highway,
    input  logic [1:0]       side,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic             locked,
    output logic             err_illegal,
    output logic             err_seq,
    output logic             err_dwell,
    output logic             err_sticky,
    output logic [CYC_W-1:0] cycle_count
);
    logic [1:0]       d_ph;
    logic             dv;
    phase_t           phase_q;
    mon_st_t          st, st_n;
    logic [CNT_W-1:0] dwell, dwell_n, exp_d;
    logic             chg, succ, e_ill, e_seq, e_dw, cyc_inc;

    traf_decode u_dec (
        .highway(highway),
        .side   (side),
        .ph     (d_ph),
        .valid  (dv)
    );

    // phase_q doubles as the "previous phase" the next sample is compared against
    always_comb begin
        exp_d   = CNT_W'(exp_dwell(phase_q, GREEN_CYC, YELLOW_CYC));
        chg     = dv && phase_t'(d_ph) != phase_q;
        succ    = phase_t'(d_ph) == next_phase(phase_q);
        e_ill   = !dv;
        e_seq   = st == TRACK && chg && !succ;
        e_dw    = st == TRACK && dv && (chg ? succ && dwell < exp_d : dwell == exp_d);
        cyc_inc = st == TRACK && chg && succ && phase_q == PH_SY;
        st_n    = !dv ? UNSYNC : st == UNSYNC ? (chg && succ ? TRACK : UNSYNC) : (e_seq ? UNSYNC : TRACK);
        dwell_n = st_n == UNSYNC ? '0 : chg ? CNT_W'(1) :
                  dwell == {CNT_W{1'b1}} ? dwell : dwell + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= UNSYNC;
            phase_q     <= PH_HG;
            dwell       <= '0;
            phase_valid <= 1'b0;
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
            err_dwell   <= 1'b0;
            err_sticky  <= 1'b0;
            cycle_count <= '0;
        end else begin
            st          <= st_n;
            phase_q     <= dv ? phase_t'(d_ph) : phase_q;
            dwell       <= dwell_n;
            phase_valid <= dv;
            err_illegal <= e_ill;
            err_seq     <= e_seq;
            err_dwell   <= e_dw;
            err_sticky  <= (err_sticky && !clr_err) || e_ill || e_seq || e_dw;
            cycle_count <= cyc_inc ? cycle_count + CYC_W'(1) : cycle_count;
        end
    end

    assign phase  = phase_q;
    assign locked = st == TRACK;
endmodule

// File: tb/tb_traf_mon.sv
// tb_traf_mon: directed-vector bench for traf_mon with hand-computed expectations
module tb_traf_mon;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  highway = 2'b10;
    logic [1:0]  side = 2'b10;
    logic        clr_err = 1'b0;
    logic [1:0]  phase;
    logic        phase_valid, locked, err_illegal, err_seq, err_dwell, err_sticky;
    logic [15:0] cycle_count;
    int          tests = 0;
    int          fails = 0;
    int          n_ill, n_seq, n_dw;

    localparam logic [3:0] HG = 4'b1000, HY = 4'b0100, SG = 4'b0010, SY = 4'b0001, BAD = 4'b1010;

    traf_mon dut (
        .clk        (clk),
        .rst        (rst),
        .highway    (highway),
        .side       (side),
        .clr_err    (clr_err),
        .phase      (phase),
        .phase_valid(phase_valid),
        .locked     (locked),
        .err_illegal(err_illegal),
        .err_seq    (err_seq),
        .err_dwell  (err_dwell),
        .err_sticky (err_sticky),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] hs, input logic c);
        {highway, side} = hs;
        clr_err = c;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        n_ill += int'(err_illegal);
        n_seq += int'(err_seq);
        n_dw  += int'(err_dwell);
    endtask

    task automatic run(input logic [3:0] hs, input int n);
        repeat (n) step(hs, 1'b0);
    endtask

    task automatic zero_cnt();
        n_ill = 0;
        n_seq = 0;
        n_dw  = 0;
    endtask

    initial begin
        zero_cnt();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", {30'd0, phase}, 0);
        chk("rst_bits", {26'd0, phase_valid, locked, err_illegal, err_seq, err_dwell, err_sticky}, 0);
        chk("rst_cnt", {16'd0, cycle_count}, 0);
        rst = 1'b0;
        run(HG, 3);
        chk("hg_unlocked", {31'd0, locked}, 0);
        chk("hg_valid", {31'd0, phase_valid}, 1);
        chk("hg_noerr", n_ill + n_seq + n_dw, 0);
        step(HY, 1'b0);
        chk("lock_on_hy", {31'd0, locked}, 1);
        chk("hy_phase", {30'd0, phase}, 1);
        run(HY, 3);
        run(SG, 11);
        run(SY, 4);
        chk("sy_phase", {30'd0, phase}, 3);
        chk("cnt_before", {16'd0, cycle_count}, 0);
        run(HG, 11);
        chk("cnt_after", {16'd0, cycle_count}, 1);
        step(HY, 1'b0);
        chk("nom_noerr", n_ill + n_seq + n_dw, 0);
        chk("nom_sticky", {31'd0, err_sticky}, 0);
        run(HY, 2);
        step(SG, 1'b0);
        chk("short_y_dw", {31'd0, err_dwell}, 1);
        chk("short_y_sticky", {31'd0, err_sticky}, 1);
        chk("short_y_locked", {31'd0, locked}, 1);
        step(SG, 1'b1);
        chk("short_y_pulse1", {31'd0, err_dwell}, 0);
        chk("clr_sticky", {31'd0, err_sticky}, 0);
        zero_cnt();
        run(SG, 9);
        chk("sg11_noerr", n_dw, 0);
        step(SG, 1'b0);
        chk("long_g_12", {31'd0, err_dwell}, 1);
        step(SG, 1'b0);
        chk("long_g_13", {31'd0, err_dwell}, 0);
        step(SY, 1'b0);
        chk("long_g_sy", {31'd0, err_dwell}, 0);
        chk("long_g_once", n_dw, 1);
        chk("long_g_locked", {31'd0, locked}, 1);
        run(SY, 3);
        step(BAD, 1'b0);
        chk("ill_pulse", {31'd0, err_illegal}, 1);
        chk("ill_unlock", {31'd0, locked}, 0);
        chk("ill_valid", {31'd0, phase_valid}, 0);
        chk("ill_hold_ph", {30'd0, phase}, 3);
        step(HG, 1'b0);
        chk("relock_hg", {31'd0, locked}, 1);
        chk("relock_cnt", {16'd0, cycle_count}, 1);
        chk("relock_noill", {31'd0, err_illegal}, 0);
        zero_cnt();
        step(SG, 1'b0);
        chk("skip_seq", {31'd0, err_seq}, 1);
        chk("skip_unlock", {31'd0, locked}, 0);
        chk("skip_nodw", {31'd0, err_dwell}, 0);
        run(SG, 3);
        step(SY, 1'b0);
        chk("resync_lock", {31'd0, locked}, 1);
        chk("resync_nodw", n_dw, 0);
        chk("resync_seq1", n_seq, 1);
        step(SY, 1'b1);
        chk("pre_clr", {31'd0, err_sticky}, 0);
        step(SG, 1'b1);
        chk("clr_race_seq", {31'd0, err_seq}, 1);
        chk("clr_race_sticky", {31'd0, err_sticky}, 1);
        step(SG, 1'b1);
        chk("clr_idle", {31'd0, err_sticky}, 0);
        chk("final_cnt", {16'd0, cycle_count}, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/traf_mon.md
Name: traf_mon

Overview:
Passive checker on the highway/side light bus driven by the traffic controller. It decodes each 2-bit light pair into a phase, tracks phase order and dwell time, and counts completed signal cycles. It raises single-cycle error pulses for illegal codes, illegal phase transitions and wrong dwell lengths. It sits beside the controller in the FSM/Traffic area and is also used as an embedded checker in benches.

Parameters:
GREEN_CYC, 11, exact cycles a green phase (HG, SG) must last
YELLOW_CYC, 4, exact cycles a yellow phase (HY, SY) must last
CNT_W, 8, dwell counter width; GREEN_CYC and YELLOW_CYC must both be < 2^CNT_W-1
CYC_W, 16, width of cycle_count

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
highway  in  2  highway light: 00 red, 01 yellow, 10 green, 11 illegal
side  in  2  side-road light, same encoding
clr_err  in  1  synchronous clear of err_sticky
phase  out  2  decoded phase: 0 HG, 1 HY, 2 SG, 3 SY
phase_valid  out  1  current sample was a legal light pair
locked  out  1  monitor is tracking a legal sequence
err_illegal  out  1  one-cycle pulse: illegal light pair sampled
err_seq  out  1  one-cycle pulse: illegal phase transition
err_dwell  out  1  one-cycle pulse: phase too short or too long
err_sticky  out  1  OR of all error pulses since last clear/reset
cycle_count  out  CYC_W  completed SY->HG transitions while locked; wraps

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high. The polarity and synchronicity are fixed.
- Reset: every output is 0, FSM in UNSYNC, dwell=0, previous phase=HG.
- Legal pairs, as {highway, side}: HG={10,00}, HY={01,00}, SG={00,10}, SY={00,01}. Every other pair is illegal, including all-red and any 11 code.
- Legal successors: HG->HY->SG->SY->HG.
- Latency: inputs are sampled on every edge. All outputs are registered and reflect the sample taken at that edge, so latency is 1 cycle.
- Illegal pair, any state:
  - err_illegal pulses; phase_valid=0; phase holds its last value.
  - FSM goes to UNSYNC and locked=0.
- UNSYNC:
  - No dwell checking.
  - On a legal change to the legal successor: go to TRACK, locked=1, dwell=1.
  - On a change to a non-successor: stay in UNSYNC with no error.
- TRACK, same phase as previous:
  - dwell increments, saturating at 2^CNT_W-1.
  - If dwell goes from expected to expected+1, err_dwell pulses once (overrun). No further dwell error is raised for that phase.
- TRACK, phase change:
  - Legal successor: if the ended phase's dwell is less than expected, err_dwell pulses (underrun). dwell restarts at 1.
  - Non-successor: err_seq pulses, go to UNSYNC, locked=0. No dwell check is made.
- cycle_count increments on every legal SY->HG transition in TRACK, even if err_dwell fires on that same edge.
- err_sticky sets on any error pulse. clr_err clears it; if an error pulse and clr_err occur on the same edge, the error wins (sticky=1).
- rst asserted mid-phase: full reset on that edge and re-sync from UNSYNC. The next partial phase is not dwell-checked.

Decomposition:
- Package traf_pkg holds:
  - light codes: RED=00, YEL=01, GRN=10
  - phase codes: PH_HG..PH_SY
  - monitor FSM state enum: UNSYNC, TRACK
  - next_phase function
  - expected-dwell function, phase -> GREEN_CYC/YELLOW_CYC
- One combinational sub-module, traf_decode: maps {highway, side} to phase plus a valid bit.
- The FSM, dwell counter and error logic live in traf_mon.

Test Plan:
1. Reset: hold rst 2 cycles with any inputs. All outputs must be 0; after release with HG held, locked stays 0 and there are no errors.
2. Nominal: HG×3, HY×4, SG×11, SY×4, HG×11, HY×1.
   - locked rises on the first HY sample.
   - No error pulses.
   - cycle_count=1 after the SY->HG edge.
3. Short yellow: while locked, HY×3 then SG. Expect err_dwell for 1 cycle at the SG sample; err_sticky=1; locked stays 1.
4. Long green: while locked, SG×13 then SY.
   - err_dwell pulses exactly once, at the 12th SG sample.
   - No pulse at SY.
5. Illegal and skip, each from a locked state:
   - {10,10}: err_illegal, locked=0.
   - HG then SG: err_seq, locked=0.
   - Afterwards, SG->SY re-locks with no dwell error on the partial SG.
6. Sticky clear: pulse clr_err on the same edge as a forced err_seq. err_sticky stays 1; clr_err on the next idle cycle clears it to 0.
